booth_div_restoring: RTL and testbench
======================================

// Module: booth_div_restoring
// PURPOSE
//  Sequential N-bit integer divider: the inverse companion of the Booth multiplier in the
//  custom-ISA execute stage.
//  Accepts dividend/divisor on a start pulse, runs one restoring shift/subtract step per clock,
//  and returns quotient and remainder with a one-cycle done pulse.
//  Implements RISC-V DIV/DIVU/REM/REMU semantics, including divide-by-zero and overflow.
// PARAMETERS
//  N        32   operand/result width in bits (>= 4)
//  CNT_W    6    iteration counter width; must satisfy 2**CNT_W > N
// PORTS
//  clk        in   1   rising-edge clock, single clock domain
//  reset      in   1   synchronous, active-high; forces IDLE
//  start      in   1   request; sampled only in IDLE
//  is_signed  in   1   1 = DIV/REM semantics, 0 = DIVU/REMU; latched with start
//  dividend   in   N   latched on the accepting edge
//  divisor    in   N   latched on the accepting edge
//  quotient   out  N   registered result, valid when done=1, held until next result
//  remainder  out  N   registered result, valid when done=1, held until next result
//  busy       out  1   1 from the cycle after acceptance until done
//  done       out  1   single-cycle pulse; results valid in that cycle
// BEHAVIOUR
//  Reset (reset=1 at posedge): state=IDLE; quotient=0, remainder=0, busy=0, done=0; counter=0.
//  Reset mid-operation aborts it: no done pulse; outputs return to 0.
//  States: IDLE -> SETUP -> ITER(xN) -> FIX -> DONE -> IDLE.
//   IDLE : busy=0. start=1 at edge k latches operands and is_signed; state <= SETUP.
//   SETUP: busy=1. Computes |dividend| and |divisor| (abs only if is_signed). Sets A=0 (N+1 bits),
//          Q=|dividend|, M=|divisor|, cnt=N. Records neg_q=sign(dd)^sign(dv) and neg_r=sign(dd).
//          Exits: divisor==0 -> DONE with q=all-ones, r=dividend.
//                 is_signed & dividend==MIN & divisor==-1 -> DONE with q=MIN, r=0.
//                 otherwise -> ITER.
//   ITER : {A,Q} <<= 1; T = A - {0,M}. If T[N]==0 then A=T, Q[0]=1; else Q[0]=0 (restore).
//          cnt decrements each cycle; when cnt reaches 1 -> FIX.
//   FIX  : q = neg_q ? -Q : Q; r = neg_r ? -A[N-1:0] : A[N-1:0]. Both are written to the output regs.
//   DONE : done=1 for exactly one cycle; busy=0; then IDLE. A new start is sampled only in IDLE,
//          so back-to-back requests are spaced by at least one cycle after done.
//  Latency, start sampled at edge k:
//   - normal: done high in cycle k+N+3
//   - div-by-zero/overflow: done high in cycle k+2
//  start while busy or in DONE: ignored; no queueing; operands are not re-latched.
//  Width rules: A is N+1 bits for the borrow detect. Negation is two's complement, mod 2**N.
//   |MIN| = MIN as unsigned, which is correct for the unsigned core.
//  Zero dividend: normal path, q=0, r=0.
//  Signed remainder takes the sign of the dividend.
//  Unused/illegal state encodings recover to IDLE on the next edge.
// STRUCTURE
//  Shared header (div_defs.vh):
//   - state localparams S_IDLE=0, S_SETUP=1, S_ITER=2, S_FIX=3, S_DONE=4 (3-bit encoding)
//   - default N and CNT_W
//  One sub-module, div_ctrl_fsm:
//   - inputs: clk, reset, start, div_zero, ovf, cnt_last
//   - outputs: ld_ops, init, step, fix, busy, done
//   - state register plus decoded one-hot control
//  Top level holds the A/Q/M/cnt datapath and the result registers.
// TESTING
//  1 unsigned 100/7 -> q=14, r=2; done exactly N+3 cycles after start; busy high for N+2 cycles.
//  2 signed -7/2 -> q=-3 (0xFFFFFFFD), r=-1; signed 7/-2 -> q=-3, r=1.
//  3 5/0 (both modes) -> q=0xFFFFFFFF, r=5; done 2 cycles after start.
//  4 signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0, fast path;
//    same operands unsigned -> q=0, r=0x80000000 after N+3 cycles.
//  5 start pulsed mid-ITER with new operands -> ignored; first result unchanged; exactly one done.
//  6 reset asserted mid-ITER -> next cycle busy=0, q=r=0, no done;
//    subsequent 0xFFFFFFFF/1 unsigned -> q=0xFFFFFFFF, r=0.

Source files
------------

// File: rtl/booth_div_restoring_pkg.sv
// Shared definitions for the restoring divider: default widths and the controller state encoding.
package booth_div_restoring_pkg;

    localparam int DEF_N     = 32;
    localparam int DEF_CNT_W = 6;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_ITER  = 3'd2,
        S_FIX   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/booth_div_restoring_div_ctrl_fsm.sv
// Sequencing controller for the restoring divider; decodes the state into one-hot datapath strobes.
//   state | meaning
//   IDLE  | waiting for start; operands latched on the accepting edge
//   SETUP | take magnitudes, load A/Q/M/cnt, or short-circuit div-by-zero/overflow
//   ITER  | one shift/subtract/restore step per cycle, N cycles
//   FIX   | apply result signs and write the output registers
//   DONE  | one-cycle done pulse
module div_ctrl_fsm
    import booth_div_restoring_pkg::*;
(
    input  logic clk_i,
    input  logic reset_i,
    input  logic start_i,
    input  logic div_zero_i,
    input  logic ovf_i,
    input  logic cnt_last_i,
    output logic ld_ops_o,
    output logic init_o,
    output logic step_o,
    output logic fix_o,
    output logic busy_o,
    output logic done_o
);

    state_t state_q, state_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = S_IDLE;
        ld_ops_o = 1'b0;
        init_o   = 1'b0;
        step_o   = 1'b0;
        fix_o    = 1'b0;
        busy_o   = 1'b0;
        done_o   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    ld_ops_o = 1'b1;
                    state_d  = S_SETUP;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_SETUP: begin
                init_o  = 1'b1;
                busy_o  = 1'b1;
                state_d = (div_zero_i || ovf_i) ? S_DONE : S_ITER;
            end
            S_ITER: begin
                step_o  = 1'b1;
                busy_o  = 1'b1;
                state_d = cnt_last_i ? S_FIX : S_ITER;
            end
            S_FIX: begin
                fix_o   = 1'b1;
                busy_o  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: rtl/booth_div_restoring.sv
// Sequential restoring divider with RISC-V DIV/DIVU/REM/REMU semantics.
// Holds the A/Q/M/counter datapath and the result registers; sequencing lives in div_ctrl_fsm.
module booth_div_restoring
    import booth_div_restoring_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic         is_signed_i,
    input  logic [N-1:0] dividend_i,
    input  logic [N-1:0] divisor_i,
    output logic [N-1:0] quotient_o,
    output logic [N-1:0] remainder_o,
    output logic         busy_o,
    output logic         done_o
);

    localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

    logic             ld_ops, init, step, fix;
    logic             div_zero, ovf, cnt_last;

    logic [N-1:0]     dd_q, dd_d, dv_q, dv_d;
    logic             sgn_q, sgn_d;
    logic [N-1:0]     a_q, a_d, q_q, q_d, m_q, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             negq_q, negq_d, negr_q, negr_d;
    logic [N-1:0]     quot_q, quot_d, rem_q, rem_d;

    logic             dd_neg, dv_neg;
    logic [N-1:0]     dd_abs, dv_abs;
    logic [N:0]       a_sh, diff;
    logic [N-1:0]     q_sh;

    div_ctrl_fsm u_ctrl (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .start_i    (start_i),
        .div_zero_i (div_zero),
        .ovf_i      (ovf),
        .cnt_last_i (cnt_last),
        .ld_ops_o   (ld_ops),
        .init_o     (init),
        .step_o     (step),
        .fix_o      (fix),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    assign div_zero = (dv_q == '0);
    assign ovf      = sgn_q && (dd_q == MIN_VAL) && (dv_q == '1);
    assign cnt_last = (cnt_q == CNT_W'(1));

    assign dd_neg = sgn_q & dd_q[N-1];
    assign dv_neg = sgn_q & dv_q[N-1];
    assign dd_abs = dd_neg ? -dd_q : dd_q;
    assign dv_abs = dv_neg ? -dv_q : dv_q;

    // The partial remainder is always below M, so it is stored in N bits; the
    // shifted value needs the extra bit so the subtraction borrow lands in diff[N].
    assign a_sh = {a_q, q_q[N-1]};
    assign q_sh = {q_q[N-2:0], 1'b0};
    assign diff = a_sh - {1'b0, m_q};

    always_comb begin
        dd_d   = dd_q;
        dv_d   = dv_q;
        sgn_d  = sgn_q;
        a_d    = a_q;
        q_d    = q_q;
        m_d    = m_q;
        cnt_d  = cnt_q;
        negq_d = negq_q;
        negr_d = negr_q;
        quot_d = quot_q;
        rem_d  = rem_q;

        if (ld_ops) begin
            dd_d  = dividend_i;
            dv_d  = divisor_i;
            sgn_d = is_signed_i;
        end

        if (init) begin
            a_d    = '0;
            q_d    = dd_abs;
            m_d    = dv_abs;
            cnt_d  = CNT_W'(N);
            negq_d = dd_neg ^ dv_neg;
            negr_d = dd_neg;
            if (div_zero) begin
                quot_d = '1;
                rem_d  = dd_q;
            end else if (ovf) begin
                quot_d = MIN_VAL;
                rem_d  = '0;
            end
        end

        if (step) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (!diff[N]) begin
                a_d = diff[N-1:0];
                q_d = {q_sh[N-1:1], 1'b1};
            end else begin
                a_d = a_sh[N-1:0];
                q_d = q_sh;
            end
        end

        if (fix) begin
            quot_d = negq_q ? -q_q : q_q;
            rem_d  = negr_q ? -a_q : a_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            dd_q   <= '0;
            dv_q   <= '0;
            sgn_q  <= 1'b0;
            a_q    <= '0;
            q_q    <= '0;
            m_q    <= '0;
            cnt_q  <= '0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
            quot_q <= '0;
            rem_q  <= '0;
        end else begin
            dd_q   <= dd_d;
            dv_q   <= dv_d;
            sgn_q  <= sgn_d;
            a_q    <= a_d;
            q_q    <= q_d;
            m_q    <= m_d;
            cnt_q  <= cnt_d;
            negq_q <= negq_d;
            negr_q <= negr_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
        end
    end

    assign quotient_o  = quot_q;
    assign remainder_o = rem_q;

endmodule

// File: tb/tb_booth_div_restoring.sv
// Scoreboard bench for booth_div_restoring: expected results from a behavioural model are queued at issue.
module tb_booth_div_restoring;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         reset, start, is_signed;
    logic [N-1:0] dividend, divisor;
    logic [N-1:0] quotient, remainder;
    logic         busy, done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        int           lat;
    } exp_t;

    exp_t sb[$];

    booth_div_restoring #(.N(N), .CNT_W(6)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start),
        .is_signed_i (is_signed),
        .dividend_i  (dividend),
        .divisor_i   (divisor),
        .quotient_o  (quotient),
        .remainder_o (remainder),
        .busy_o      (busy),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic s, input logic [N-1:0] dd, input logic [N-1:0] dv);
        exp_t e;
        logic signed [N-1:0] sdd, sdv;
        sdd   = dd;
        sdv   = dv;
        e.lat = N + 3;
        if (dv == '0) begin
            e.q = '1; e.r = dd; e.lat = 2;
        end else if (s && dd == 32'h8000_0000 && dv == '1) begin
            e.q = 32'h8000_0000; e.r = '0; e.lat = 2;
        end else if (s) begin
            e.q = sdd / sdv; e.r = sdd % sdv;
        end else begin
            e.q = dd / dv; e.r = dd % dv;
        end
        return e;
    endfunction

    // Pushes the expectation and pulses start for one cycle; returns just after the accepting edge.
    task automatic issue(input logic s, input logic [N-1:0] dd, input logic [N-1:0] dv);
        sb.push_back(model(s, dd, dv));
        @(posedge clk); #1;
        start = 1'b1; is_signed = s; dividend = dd; divisor = dv;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // lat counts cycles from the start cycle to the done cycle inclusive of the step into done.
    task automatic wait_done(output int lat, output int busy_cnt, output bit ok);
        lat = 1; busy_cnt = 0; ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (quotient !== '0) begin failures++; $display("FAIL reset_q got=%h exp=0", quotient); end
        checks++; if (remainder !== '0) begin failures++; $display("FAIL reset_r got=%h exp=0", remainder); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL idle_after_reset busy=%b done=%b exp=0/0", busy, done); end
    endtask

    task automatic test_unsigned();
        logic [N-1:0] dds [4] = '{32'd100, 32'd0, 32'hFFFF_FFFF, 32'd12345678};
        logic [N-1:0] dvs [4] = '{32'd7, 32'd9, 32'd1, 32'd1000};
        int lat, bc; bit ok; exp_t e;
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, dds[i], dvs[i]);
            wait_done(lat, bc, ok);
            e = sb.pop_front();
            checks++; if (!ok) begin failures++; $display("FAIL unsigned_timeout[%0d] done never seen", i); end
            checks++; if (quotient !== e.q) begin failures++; $display("FAIL unsigned_q[%0d] got=%h exp=%h", i, quotient, e.q); end
            checks++; if (remainder !== e.r) begin failures++; $display("FAIL unsigned_r[%0d] got=%h exp=%h", i, remainder, e.r); end
            checks++; if (lat != e.lat) begin failures++; $display("FAIL unsigned_lat[%0d] got=%0d exp=%0d", i, lat, e.lat); end
            if (i == 0) begin
                checks++; if (bc != N + 2) begin failures++; $display("FAIL unsigned_busy_len got=%0d exp=%0d", bc, N + 2); end
                checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_in_done got=%b exp=0", busy); end
                @(posedge clk); #1;
                checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_pulse_width got=%b exp=0", done); end
                checks++; if (quotient !== e.q) begin failures++; $display("FAIL result_hold got=%h exp=%h", quotient, e.q); end
            end
        end
    endtask

    task automatic test_signed();
        logic [N-1:0] dds [5] = '{-32'sd7, 32'sd7, -32'sd7, 32'sd0, -32'sd100};
        logic [N-1:0] dvs [5] = '{32'sd2, -32'sd2, -32'sd2, -32'sd5, 32'sd7};
        int lat, bc; bit ok; exp_t e;
        for (int i = 0; i < 5; i++) begin
            issue(1'b1, dds[i], dvs[i]);
            wait_done(lat, bc, ok);
            e = sb.pop_front();
            checks++; if (!ok) begin failures++; $display("FAIL signed_timeout[%0d] done never seen", i); end
            checks++; if (quotient !== e.q) begin failures++; $display("FAIL signed_q[%0d] got=%h exp=%h", i, quotient, e.q); end
            checks++; if (remainder !== e.r) begin failures++; $display("FAIL signed_r[%0d] got=%h exp=%h", i, remainder, e.r); end
            checks++; if (lat != e.lat) begin failures++; $display("FAIL signed_lat[%0d] got=%0d exp=%0d", i, lat, e.lat); end
        end
    endtask

    task automatic test_div_zero();
        logic         sg  [3] = '{1'b0, 1'b1, 1'b1};
        logic [N-1:0] dds [3] = '{32'd5, 32'd5, -32'sd5};
        int lat, bc; bit ok; exp_t e;
        for (int i = 0; i < 3; i++) begin
            issue(sg[i], dds[i], '0);
            wait_done(lat, bc, ok);
            e = sb.pop_front();
            checks++; if (!ok) begin failures++; $display("FAIL divzero_timeout[%0d] done never seen", i); end
            checks++; if (quotient !== e.q) begin failures++; $display("FAIL divzero_q[%0d] got=%h exp=%h", i, quotient, e.q); end
            checks++; if (remainder !== e.r) begin failures++; $display("FAIL divzero_r[%0d] got=%h exp=%h", i, remainder, e.r); end
            checks++; if (lat != e.lat) begin failures++; $display("FAIL divzero_lat[%0d] got=%0d exp=%0d", i, lat, e.lat); end
        end
    endtask

    task automatic test_overflow();
        int lat, bc; bit ok; exp_t e;
        for (int i = 0; i < 2; i++) begin
            issue(i == 0, 32'h8000_0000, 32'hFFFF_FFFF);
            wait_done(lat, bc, ok);
            e = sb.pop_front();
            checks++; if (!ok) begin failures++; $display("FAIL ovf_timeout[%0d] done never seen", i); end
            checks++; if (quotient !== e.q) begin failures++; $display("FAIL ovf_q[%0d] got=%h exp=%h", i, quotient, e.q); end
            checks++; if (remainder !== e.r) begin failures++; $display("FAIL ovf_r[%0d] got=%h exp=%h", i, remainder, e.r); end
            checks++; if (lat != e.lat) begin failures++; $display("FAIL ovf_lat[%0d] got=%0d exp=%0d", i, lat, e.lat); end
        end
    endtask

    task automatic test_start_ignored();
        int lat, bc, extra; bit ok; exp_t e;
        issue(1'b0, 32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1; is_signed = 1'b1; dividend = 32'd55; divisor = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ignored_busy got=%b exp=1", busy); end
        wait_done(lat, bc, ok);
        e = sb.pop_front();
        checks++; if (!ok) begin failures++; $display("FAIL ignored_timeout done never seen"); end
        checks++; if (quotient !== e.q) begin failures++; $display("FAIL ignored_q got=%h exp=%h", quotient, e.q); end
        checks++; if (remainder !== e.r) begin failures++; $display("FAIL ignored_r got=%h exp=%h", remainder, e.r); end
        extra = 0;
        for (int i = 0; i < N + 6; i++) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        checks++; if (extra != 0) begin failures++; $display("FAIL ignored_extra_done got=%0d exp=0", extra); end
    endtask

    task automatic test_reset_mid();
        int lat, bc, seen; bit ok; exp_t e;
        issue(1'b0, 32'd999, 32'd4);
        void'(sb.pop_back());
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy); end
        checks++; if (quotient !== '0 || remainder !== '0) begin failures++; $display("FAIL midreset_outputs q=%h r=%h exp=0/0", quotient, remainder); end
        seen = 0;
        for (int i = 0; i < N + 6; i++) begin
            if (done) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL midreset_done got=%0d exp=0", seen); end
        issue(1'b0, 32'hFFFF_FFFF, 32'd1);
        wait_done(lat, bc, ok);
        e = sb.pop_front();
        checks++; if (!ok) begin failures++; $display("FAIL postreset_timeout done never seen"); end
        checks++; if (quotient !== e.q) begin failures++; $display("FAIL postreset_q got=%h exp=%h", quotient, e.q); end
        checks++; if (remainder !== e.r) begin failures++; $display("FAIL postreset_r got=%h exp=%h", remainder, e.r); end
    endtask

    task automatic test_random();
        int lat, bc; bit ok; exp_t e;
        logic s; logic [N-1:0] dd, dv;
        for (int i = 0; i < 16; i++) begin
            s  = 1'($urandom_range(1, 0));
            dd = $urandom;
            case ($urandom_range(3, 0))
                0:       dv = '0;
                1:       dv = 32'($urandom_range(15, 1));
                2:       dv = -32'($urandom_range(15, 1));
                default: dv = $urandom;
            endcase
            issue(s, dd, dv);
            wait_done(lat, bc, ok);
            e = sb.pop_front();
            checks++; if (!ok) begin failures++; $display("FAIL random_timeout[%0d] done never seen", i); end
            checks++; if (quotient !== e.q || remainder !== e.r) begin
                failures++;
                $display("FAIL random[%0d] s=%b dd=%h dv=%h got q=%h r=%h exp q=%h r=%h", i, s, dd, dv, quotient, remainder, e.q, e.r);
            end
            checks++; if (lat != e.lat) begin failures++; $display("FAIL random_lat[%0d] got=%0d exp=%0d", i, lat, e.lat); end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
